// File: rtl/cpu_mem_pkg.sv
// Shared types for the unified-memory arbiter.
// Provides the arbiter state and owner encodings plus default bus widths.
package cpu_mem_pkg;

    localparam int unsigned ADDR_W_DEF = 16;
    localparam int unsigned DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        ACC  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    typedef enum logic {
        OWN_DM = 1'b0,
        OWN_IF = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/mem_lat_counter.sv
// Loadable down-counter that times one fixed-latency memory access.
// Ports:
//   clk, rst  - clock, asynchronous active-high reset
//   i_load    - load LAT-1 (start of an access)
//   i_dec     - decrement by one, saturating at zero
//   o_zero    - counter currently at zero (last access cycle)
module mem_lat_counter #(
    parameter int unsigned LAT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_load,
    input  logic i_dec,
    output logic o_zero
);

    // LAT=1 would give a zero-width counter; keep at least one bit.
    localparam int unsigned CW = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] LOAD_VAL = CW'(LAT - 1);

    logic [CW-1:0] r_count;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_load) begin
            r_count <= LOAD_VAL;
        end else if (i_dec && (r_count != '0)) begin
            r_count <= r_count - CW'(1);
        end
    end

    assign o_zero = (r_count == '0);

endmodule

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter for the five-stage pipeline.
// Shares one fixed-latency memory between instruction fetch (IF) and the
// memory stage (DM); DM wins contention. Holds mem_* stable for LAT cycles,
// returns read data with a one-cycle valid pulse, and drives stage stalls.
// Ports:
//   clk, rst                 - clock, asynchronous active-high reset
//   if_req/if_addr           - fetch request (held until if_valid) and PC
//   if_rdata/if_valid        - fetched instruction and its one-cycle strobe
//   if_stall                 - fetch stage must freeze
//   dm_re/dm_we/dm_addr/dm_wdata - data request (held until dm_valid)
//   dm_rdata/dm_valid        - load data and completion strobe
//   dm_stall                 - memory stage must freeze
//   flush                    - kill an in-flight fetch
//   hlt                      - stop granting new fetches
//   mem_addr/mem_wdata/mem_re/mem_we - registered memory interface
//   mem_rdata                - memory read data, valid in last access cycle
module mem_arbiter
    import cpu_mem_pkg::*;
#(
    parameter int unsigned ADDR_W = ADDR_W_DEF,
    parameter int unsigned DATA_W = DATA_W_DEF,
    parameter int unsigned LAT    = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    output logic              if_stall,
    input  logic              dm_re,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_valid,
    output logic              dm_stall,
    input  logic              flush,
    input  logic              hlt,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_re,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        r_state;
    arb_owner_t        r_owner;
    logic              r_kill;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic              r_mem_re;
    logic              r_mem_we;
    logic [DATA_W-1:0] r_if_rdata;
    logic              r_if_valid;
    logic [DATA_W-1:0] r_dm_rdata;
    logic              r_dm_valid;

    logic w_dm_req;
    logic w_if_grant;
    logic w_grant;
    logic w_kill_next;
    logic w_cnt_zero;

    assign w_dm_req   = dm_re | dm_we;
    assign w_if_grant = if_req & ~hlt;
    assign w_grant    = (r_state == IDLE) & (w_dm_req | w_if_grant);
    // A flush landing in the final ACC cycle must still suppress capture.
    assign w_kill_next = r_kill | (flush & (r_owner == OWN_IF));

    mem_lat_counter #(
        .LAT (LAT)
    ) u_cnt (
        .clk    (clk),
        .rst    (rst),
        .i_load (w_grant),
        .i_dec  (r_state == ACC),
        .o_zero (w_cnt_zero)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= IDLE;
            r_owner     <= OWN_DM;
            r_kill      <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_mem_re    <= 1'b0;
            r_mem_we    <= 1'b0;
            r_if_rdata  <= '0;
            r_if_valid  <= 1'b0;
            r_dm_rdata  <= '0;
            r_dm_valid  <= 1'b0;
        end else begin
            r_if_valid <= 1'b0;
            r_dm_valid <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_dm_req) begin
                        r_owner     <= OWN_DM;
                        r_kill      <= 1'b0;
                        r_mem_addr  <= dm_addr;
                        r_mem_wdata <= dm_wdata;
                        r_mem_we    <= dm_we;
                        // Simultaneous read+write is treated as a write only.
                        r_mem_re    <= dm_re & ~dm_we;
                        r_state     <= ACC;
                    end else if (w_if_grant) begin
                        r_owner    <= OWN_IF;
                        r_kill     <= flush;
                        r_mem_addr <= if_addr;
                        r_mem_re   <= 1'b1;
                        r_mem_we   <= 1'b0;
                        r_state    <= ACC;
                    end
                end
                ACC: begin
                    r_kill <= w_kill_next;
                    if (w_cnt_zero) begin
                        if (r_mem_re && !w_kill_next) begin
                            if (r_owner == OWN_IF) begin
                                r_if_rdata <= mem_rdata;
                            end else begin
                                r_dm_rdata <= mem_rdata;
                            end
                        end
                        // Valid is registered here so it is high during RESP.
                        if (r_owner == OWN_IF) begin
                            r_if_valid <= ~w_kill_next;
                        end else begin
                            r_dm_valid <= 1'b1;
                        end
                        r_mem_re <= 1'b0;
                        r_mem_we <= 1'b0;
                        r_state  <= RESP;
                    end
                end
                RESP: begin
                    r_kill  <= 1'b0;
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
        end
    end

    assign mem_addr  = r_mem_addr;
    assign mem_wdata = r_mem_wdata;
    assign mem_re    = r_mem_re;
    assign mem_we    = r_mem_we;
    assign if_rdata  = r_if_rdata;
    assign if_valid  = r_if_valid;
    assign dm_rdata  = r_dm_rdata;
    assign dm_valid  = r_dm_valid;
    assign if_stall  = if_req & ~r_if_valid;
    assign dm_stall  = w_dm_req & ~r_dm_valid;

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter and access sequencer for the 16-bit five-stage pipeline. It shares one fixed-latency unified memory between the instruction-fetch stage and the memory stage, with data accesses given priority. It holds address, data and enables stable for the full access and returns read data with a one-cycle valid pulse. It also drives the per-stage stall signals the pipeline uses to freeze while an access is outstanding.

## Interface
- ADDR_W, 16, address width
- DATA_W, 16, data width
- LAT, 4, memory access cycles (≥1)

- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous, active-high reset
- if_req  in  1  fetch request, held until if_valid
- if_addr  in  ADDR_W  fetch address (PC)
- if_rdata  out  DATA_W  fetched instruction, registered, holds last value
- if_valid  out  1  one-cycle pulse: if_rdata fresh
- if_stall  out  1  if_req && !if_valid
- dm_re, dm_we  in  1  data read / write request, held until dm_valid
- dm_addr  in  ADDR_W  data address
- dm_wdata  in  DATA_W  store data
- dm_rdata  out  DATA_W  load data, registered, holds last value
- dm_valid  out  1  one-cycle pulse: data access complete
- dm_stall  out  1  (dm_re|dm_we) && !dm_valid
- flush  in  1  branch/jump taken: kill in-flight fetch
- hlt  in  1  stop granting fetches
- mem_addr  out  ADDR_W  memory address, registered
- mem_wdata  out  DATA_W  memory write data, registered
- mem_re, mem_we  out  1  memory enables, registered
- mem_rdata  in  DATA_W  memory read data, valid in last ACC cycle

## Operation
- FSM states: IDLE, ACC, RESP. Owner register: DM or IF. Kill flag.
- IDLE: if dm_re|dm_we, grant DM. Otherwise, if if_req && !hlt, grant IF. Otherwise stay in IDLE.
- Grant: latch addr/wdata/enables into mem_*, load counter = LAT-1, go to ACC. Kill is set to flush if owner is IF, else 0.
- DM with both dm_we and dm_re high: write only. mem_re=0, dm_rdata unchanged.
- ACC: mem_* held constant. Counter decrements each cycle. A flush while owner=IF sets kill. At counter 0: capture mem_rdata into the owner's rdata reg (reads only, and not if killed), clear mem_re/mem_we, go to RESP.
- RESP: pulse owner valid, suppressed if killed. Requests are ignored this cycle because they are stale. Clear kill and go to IDLE.
- Flush during a killed access: the memory access still runs its full LAT cycles because it cannot abort. if_rdata is unchanged. The fetch stage may change if_addr; the new fetch competes in the next IDLE.
- Flush in RESP or IDLE: no effect on the arbiter.
- hlt blocks only new IF grants. In-flight accesses and DM accesses proceed.
- Rdata registers are written only on a completing, unkilled read for their owner.

## Timing
- Reset (async, immediate): state IDLE, kill 0, all outputs 0 including mem_re/mem_we, rdata regs 0x0000. A reset mid-access abandons the access with no valid pulse.
- Request high in IDLE at cycle T: mem_* active cycles T+1..T+LAT. mem_rdata sampled at the end of T+LAT. Valid pulse in cycle T+LAT+1. The next grant is possible at the earliest in cycle T+LAT+2.
- Throughput: one access per LAT+2 cycles.
- Stall is combinational from inputs and registered valid. It is high from the request cycle through T+LAT, and low in the valid cycle.
- Contention: DM wins in IDLE. A fetch waits at most one full DM access because a DM request cannot repeat in the next IDLE without pipeline advance.
- Counter width: $clog2(LAT). LAT=1 means a single ACC cycle.

## Structure
- Package cpu_mem_pkg:
  - state enum {IDLE, ACC, RESP}
  - owner enum {OWN_DM, OWN_IF}
  - ADDR_W/DATA_W defaults
- One sub-module, mem_lat_counter: loadable down-counter with a zero flag, parameterised by LAT.
- The remainder (FSM, grant mux, output regs) lives in mem_arbiter.

## Test plan
All scenarios use LAT=4, with requests raised at cycle 0.
- IF only, if_addr=0x0010, mem_rdata=0xA5A5:
  - mem_re=1 with mem_addr=0x0010 in cycles 1–4.
  - if_valid in cycle 5 with if_rdata=0xA5A5.
  - if_stall high in cycles 0–4.
- IF and DM read (dm_addr=0x0200, mem_rdata=0x1111) together:
  - DM is served first, dm_valid in cycle 5 with 0x1111.
  - IF is granted in cycle 6, if_valid in cycle 11.
- DM write, dm_addr=0x00F0, dm_wdata=0x1234:
  - mem_we=1 with stable addr/data in cycles 1–4, mem_re=0.
  - dm_valid in cycle 5, dm_rdata unchanged.
- IF fetch of 0x0010 with flush in cycle 2:
  - mem_re is still high in cycles 1–4.
  - No if_valid pulse, if_rdata unchanged.
  - A new fetch of 0x0040 is granted in cycle 6 and completes in cycle 11.
- hlt=1 with if_req=1:
  - mem_re never asserts.
  - A DM read raised at cycle 3 completes with dm_valid in cycle 8.
- rst asserted in cycle 2 of an IF access:
  - mem_re, if_valid and rdata regs are 0 immediately, with no later pulse.
  - After release, a new IF request completes in LAT+1 cycles.
